// File: rtl/uart_rx_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl_pkg
// Shared definitions for the UART receive controller slice (the uart_define
// set): FSM state codes, default RX FIFO depth and divider width.
// No ports; imported by uart_rx_ctrl and uart_rx_fifo.
// -----------------------------------------------------------------------------
package uart_rx_ctrl_pkg;

  // Default number of RX FIFO entries (must be a power of two, >= 2).
  localparam int UART_FIFO_DEPTH_DEF = 8;

  // Width of the sample-tick divider reload value.
  localparam int UART_DIV_W = 16;

  // Receive controller FSM state codes.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,  // receiver disabled, divider parked at reload
    ST_RUN   = 2'b01,  // receiving, waiting for frame completion
    ST_CAPT  = 2'b10,  // single-cycle capture of the received byte
    ST_DRAIN = 2'b11   // wait for the receiver to leave its stop phase
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Single-clock synchronous byte FIFO for received UART data.
// A push while full is accepted only when a pop happens in the same cycle;
// otherwise the byte is dropped (the caller flags the overrun). A pop while
// empty is ignored. The head is shown combinationally and reads 0 when empty.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push, wdata  write request and byte
//   pop          read request (advances head)
//   rdata        current head byte (0 when empty)
//   empty, full  occupancy flags
//   level        number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module uart_rx_fifo
  import uart_rx_ctrl_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH_DEF,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [7:0]       wdata,
  input  logic             pop,
  output logic [7:0]       rdata,
  output logic             empty,
  output logic             full,
  output logic [LVL_W-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LVL_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == '0);
  assign full  = (count == LVL_W'(DEPTH));
  assign level = count;

  // A pop frees a slot in the same cycle, so push+pop when full both happen.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointers are AW bits wide, so the +1 wraps modulo DEPTH for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; validity is tracked by count, and leaving the
  // array unreset lets it map onto plain RAM/register-file cells.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
// Control wrapper around a UART bit receiver: generates the 16x sample tick,
// sequences one byte capture per frame, buffers bytes in a FIFO and keeps
// sticky error flags plus a registered interrupt.
//
// Optional feature: define UART_RX_TIMEOUT_EN to add an idle-timeout counter
// (timeout flag after TIMEOUT_TICKS sample ticks with unread data while
// receiving). Without it, timeout is tied to 0.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cfg_en, cfg_div                 enable, sample-tick period minus 1
//   cfg_no_parity, cfg_ev_parity    parity mode, latched when leaving IDLE
//   rx_data_sample, rx_en           tick and enable to the receiver
//   no_parity, ev_parity            latched parity mode to the receiver
//   rd_data_flag                    capture strobe to the receiver
//   rx_ok, rxd_out, parity_error    frame-complete, byte, parity status in
//   rd_en, rd_data, rd_valid        host pop, FIFO head, FIFO not empty
//   fifo_level                      FIFO entry count
//   overrun, perr, err_clr          sticky flags and their clear
//   timeout, irq                    idle timeout, interrupt
// -----------------------------------------------------------------------------
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH    = UART_FIFO_DEPTH_DEF,
  parameter int IRQ_LVL       = 4,
  parameter int TIMEOUT_TICKS = 640
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_en,
  input  logic [UART_DIV_W-1:0]         cfg_div,
  input  logic                          cfg_no_parity,
  input  logic                          cfg_ev_parity,
  output logic                          rx_data_sample,
  output logic                          rx_en,
  output logic                          no_parity,
  output logic                          ev_parity,
  output logic                          rd_data_flag,
  input  logic                          rx_ok,
  input  logic [7:0]                    rxd_out,
  input  logic                          parity_error,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overrun,
  output logic                          perr,
  input  logic                          err_clr,
  output logic                          timeout,
  output logic                          irq
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  rx_state_e             state;
  rx_state_e             state_nxt;
  logic [UART_DIV_W-1:0] div_cnt;
  logic                  capt;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  drop;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order blocks are evaluated in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = ST_RUN;
      ST_RUN:   if (rx_ok) state_nxt = ST_CAPT;
      ST_CAPT:  state_nxt = ST_DRAIN;
      ST_DRAIN: if (!rx_ok) state_nxt = ST_RUN;
      default:  state_nxt = ST_IDLE;
    endcase
    // Disable overrides every transition, including IDLE->RUN.
    if (!cfg_en) state_nxt = ST_IDLE;
  end

  assign capt         = (state == ST_CAPT);
  assign rd_data_flag = capt;
  assign rx_en        = (state != ST_IDLE);

  // Parity mode is sampled only on the IDLE->RUN edge and frozen otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      no_parity <= 1'b0;
      ev_parity <= 1'b0;
    end else if (state == ST_IDLE && cfg_en) begin
      no_parity <= cfg_no_parity;
      ev_parity <= cfg_ev_parity;
    end
  end

  // ---------------------------------------------------------------------------
  // Sample-tick divider: parked at cfg_div in IDLE, counts down while active,
  // ticks at 0 and reloads. Reset clears it; the mandatory IDLE cycle after
  // reset reloads it before the first active count.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 div_cnt <= '0;
    else if (state == ST_IDLE)  div_cnt <= cfg_div;
    else if (div_cnt == '0)     div_cnt <= cfg_div;
    else                        div_cnt <= div_cnt - 1'b1;
  end

  assign rx_data_sample = (state != ST_IDLE) && (div_cnt == '0);

  // ---------------------------------------------------------------------------
  // Byte FIFO
  // ---------------------------------------------------------------------------
  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (capt),
    .wdata (rxd_out),
    .pop   (rd_en),
    .rdata (rd_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level)
  );

  assign rd_valid = !fifo_empty;

  // Capture into a full FIFO loses the byte unless the host pops this cycle.
  assign drop = capt && fifo_full && !(rd_en && !fifo_empty);

  // Sticky flags: a same-cycle set takes priority over err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
      perr    <= 1'b0;
    end else begin
      if (drop)              overrun <= 1'b1;
      else if (err_clr)      overrun <= 1'b0;
      if (capt && parity_error) perr <= 1'b1;
      else if (err_clr)         perr <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Idle timeout
  // ---------------------------------------------------------------------------
`ifdef UART_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);

  logic [TO_W-1:0] idle_cnt;
  logic            idle_inc;

  assign idle_inc = rx_data_sample && (state == ST_RUN) && !fifo_empty;

  // The counter saturates at TIMEOUT_TICKS and timeout is set only on the
  // step that reaches it, so err_clr stays effective while data remains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      if (capt || rd_en || fifo_empty)
        idle_cnt <= '0;
      else if (idle_inc && idle_cnt != TO_W'(TIMEOUT_TICKS))
        idle_cnt <= idle_cnt + 1'b1;

      if (rd_en || capt || err_clr)
        timeout <= 1'b0;
      else if (!fifo_empty && idle_inc && idle_cnt == TO_W'(TIMEOUT_TICKS - 1))
        timeout <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Interrupt, registered from the current level and flags.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq <= 1'b0;
    else        irq <= (fifo_level >= LVL_W'(IRQ_LVL)) | overrun | perr | timeout;
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_ctrl
// Self-checking bench for uart_rx_ctrl. The bench plays the bit receiver
// (rx_ok / rxd_out / parity_error driven on sample ticks) and the host, and
// keeps a queue-based model of the FIFO contents and sticky flags.
// Inputs are driven and outputs sampled on the falling clock edge.
// Define UART_RX_TIMEOUT_EN for the idle-timeout scenario.
// -----------------------------------------------------------------------------
module tb_uart_rx_ctrl;

  localparam int DEPTH   = 8;
  localparam int IRQ_LVL = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_en;
  logic [15:0] cfg_div;
  logic        cfg_no_parity;
  logic        cfg_ev_parity;
  logic        rx_data_sample;
  logic        rx_en;
  logic        no_parity;
  logic        ev_parity;
  logic        rd_data_flag;
  logic        rx_ok;
  logic [7:0]  rxd_out;
  logic        parity_error;
  logic        rd_en;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [3:0]  fifo_level;
  logic        overrun;
  logic        perr;
  logic        err_clr;
  logic        timeout;
  logic        irq;

  uart_rx_ctrl #(
    .FIFO_DEPTH    (DEPTH),
    .IRQ_LVL       (IRQ_LVL),
    .TIMEOUT_TICKS (640)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_en         (cfg_en),
    .cfg_div        (cfg_div),
    .cfg_no_parity  (cfg_no_parity),
    .cfg_ev_parity  (cfg_ev_parity),
    .rx_data_sample (rx_data_sample),
    .rx_en          (rx_en),
    .no_parity      (no_parity),
    .ev_parity      (ev_parity),
    .rd_data_flag   (rd_data_flag),
    .rx_ok          (rx_ok),
    .rxd_out        (rxd_out),
    .parity_error   (parity_error),
    .rd_en          (rd_en),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .fifo_level     (fifo_level),
    .overrun        (overrun),
    .perr           (perr),
    .err_clr        (err_clr),
    .timeout        (timeout),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [7:0] model_q[$];
  logic       m_ovr;
  logic       m_perr;
  logic       m_to;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_head();
    return (model_q.size() != 0) ? model_q[0] : 8'h00;
  endfunction

  // Full visible status against the model, after irq has had time to settle.
  task automatic check_status(input string tag);
    logic exp_irq;
    repeat (2) @(negedge clk);
    exp_irq = (model_q.size() >= IRQ_LVL) | m_ovr | m_perr | m_to;
    check({tag, "_level"},   32'(fifo_level), 32'(model_q.size()));
    check({tag, "_valid"},   32'(rd_valid),   32'(model_q.size() != 0));
    check({tag, "_head"},    32'(rd_data),    32'(m_head()));
    check({tag, "_overrun"}, 32'(overrun),    32'(m_ovr));
    check({tag, "_perr"},    32'(perr),       32'(m_perr));
    check({tag, "_timeout"}, 32'(timeout),    32'(m_to));
    check({tag, "_irq"},     32'(irq),        32'(exp_irq));
  endtask

  task automatic pop_one(input string tag);
    check({tag, "_pop_head"}, 32'(rd_data), 32'(m_head()));
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    if (model_q.size() != 0) void'(model_q.pop_front());
  endtask

  task automatic wait_tick(input string tag);
    int guard = 0;
    while (!rx_data_sample && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_tick_seen"}, 32'(guard < 100), 32'd1);
  endtask

  // One receiver frame: rx_ok high for 8 sample ticks carrying byte b.
  // pop_c / clr_c raise rd_en / err_clr during the capture cycle.
  task automatic send_frame(input string tag, input logic [7:0] b, input logic pe,
                            input bit pop_c, input bit clr_c);
    int flag_n = 0;
    int ticks  = 0;
    int guard  = 0;
    wait_tick(tag);
    rx_ok = 1'b1; rxd_out = b; parity_error = pe;
    while (ticks < 8 && guard < 400) begin
      @(negedge clk);
      guard++;
      rd_en = 1'b0; err_clr = 1'b0;
      if (rd_data_flag) begin
        flag_n++;
        if (pop_c) begin
          check({tag, "_capt_head"}, 32'(rd_data), 32'(m_head()));
          rd_en = 1'b1;
        end
        if (clr_c) err_clr = 1'b1;
      end
      if (rx_data_sample) ticks++;
    end
    rd_en = 1'b0; err_clr = 1'b0;
    rx_ok = 1'b0; parity_error = 1'b0;
    repeat (2) @(negedge clk);
    // Model: clear first, then pop, then push (set wins over clear).
    if (clr_c) begin m_ovr = 1'b0; m_perr = 1'b0; end
    if (pop_c && model_q.size() != 0) void'(model_q.pop_front());
    if (model_q.size() < DEPTH) model_q.push_back(b);
    else                        m_ovr = 1'b1;
    if (pe) m_perr = 1'b1;
    check({tag, "_flag_cycles"}, 32'(flag_n), 32'd1);
  endtask

  function automatic int count_ticks(input int n);
    return n;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    logic [7:0] b;
    int guard;

    m_ovr = 1'b0; m_perr = 1'b0; m_to = 1'b0;
    rst_n = 1'b0; cfg_en = 1'b0; cfg_div = 16'd3;
    cfg_no_parity = 1'b0; cfg_ev_parity = 1'b0;
    rx_ok = 1'b0; rxd_out = 8'h00; parity_error = 1'b0;
    rd_en = 1'b0; err_clr = 1'b0;

    // Reset: all outputs low.
    repeat (3) @(negedge clk);
    check("rst_outputs", {rx_data_sample, rx_en, no_parity, ev_parity, rd_data_flag,
                          rd_valid, overrun, perr, timeout, irq}, 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_level",   32'(fifo_level), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_tick", {rx_en, rx_data_sample}, 32'd0);

    // Enable with parity mode latched on the IDLE->RUN edge.
    cfg_no_parity = 1'b1; cfg_ev_parity = 1'b0; cfg_en = 1'b1;
    @(negedge clk);
    cfg_no_parity = 1'b0; cfg_ev_parity = 1'b1;
    @(negedge clk);
    check("en_rx_en",     32'(rx_en),     32'd1);
    check("latch_no_par", 32'(no_parity), 32'd1);
    check("latch_ev_par", 32'(ev_parity), 32'd0);

    // Tick period cfg_div+1: 40 cycles hold exactly 40/4 ticks.
    repeat (6) @(negedge clk);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rx_data_sample) pulses++;
    end
    check("tick_div3", 32'(pulses), 32'(count_ticks(40 / 4)));

    // cfg_div=0: tick every cycle.
    cfg_div = 16'd0;
    repeat (8) @(negedge clk);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rx_data_sample) pulses++;
    end
    check("tick_div0", 32'(pulses), 32'd10);
    check("par_stable", {no_parity, ev_parity}, 32'b10);

    // Disabled: no ticks, rx_en low.
    cfg_en = 1'b0; cfg_div = 16'd3;
    repeat (2) @(negedge clk);
    check("dis_rx_en", 32'(rx_en), 32'd0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rx_data_sample) pulses++;
    end
    check("tick_disabled", 32'(pulses), 32'd0);

    // Re-enable picks up the new parity mode.
    cfg_en = 1'b1;
    repeat (2) @(negedge clk);
    check("relatch_par", {no_parity, ev_parity}, 32'b01);

    // Single frame with A5.
    send_frame("a5", 8'hA5, 1'b0, 0, 0);
    check_status("a5");
    pop_one("a5");
    check_status("a5_popped");

    // Pop when empty is ignored.
    rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;
    check_status("pop_empty");

    // Nine frames, no pops: FIFO fills, ninth byte dropped.
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom_range(0, 255));
      send_frame($sformatf("fill%0d", i), b, 1'b0, 0, 0);
    end
    check_status("full_ovr");

    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    m_ovr = 1'b0;
    check_status("ovr_clr");

    // Push and pop together while full: both happen, no overrun.
    b = 8'($urandom_range(0, 255));
    send_frame("push_pop_full", b, 1'b0, 1, 0);
    check_status("push_pop_full");

    // Drain and compare every byte (pointers have wrapped by now).
    for (int i = 0; i < DEPTH; i++) pop_one($sformatf("drain%0d", i));
    check_status("drained");

    // Parity error: byte stored, perr and irq set.
    b = 8'($urandom_range(0, 255));
    send_frame("perr", b, 1'b1, 0, 0);
    check_status("perr");
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    m_perr = 1'b0;
    check("perr_clr",     32'(perr), 32'd0);
    check("irq_latency",  32'(irq),  32'd1);
    @(negedge clk);
    check("irq_after_clr", 32'(irq), 32'd0);

    // err_clr during a parity-error capture: set wins.
    b = 8'($urandom_range(0, 255));
    send_frame("set_wins", b, 1'b1, 0, 1);
    check_status("set_wins");
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    m_perr = 1'b0;

    // irq threshold: level 3 below, level 4 at threshold.
    b = 8'($urandom_range(0, 255));
    send_frame("lvl3", b, 1'b0, 0, 0);
    check_status("lvl3");
    b = 8'($urandom_range(0, 255));
    send_frame("lvl4", b, 1'b0, 0, 0);
    check_status("lvl4");

    // cfg_en dropped during DRAIN: IDLE next cycle, FIFO untouched.
    b = 8'($urandom_range(0, 255));
    wait_tick("drop");
    rx_ok = 1'b1; rxd_out = b;
    guard = 0;
    while (!rd_data_flag && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("drop_capt_seen", 32'(guard < 100), 32'd1);
    model_q.push_back(b);
    @(negedge clk);
    cfg_en = 1'b0;
    @(negedge clk);
    check("drop_rx_en",  32'(rx_en), 32'd0);
    check("drop_level",  32'(fifo_level), 32'(model_q.size()));
    rx_ok = 1'b0;
    check_status("drop_retained");
    cfg_en = 1'b1;
    repeat (2) @(negedge clk);

`ifdef UART_RX_TIMEOUT_EN
    // Idle timeout with one unread byte, one tick per cycle.
    while (model_q.size() != 0) pop_one("to_pre");
    cfg_div = 16'd0;
    repeat (2) @(negedge clk);
    b = 8'($urandom_range(0, 255));
    send_frame("to", b, 1'b0, 0, 0);
    repeat (500) @(negedge clk);
    check("to_early", 32'(timeout), 32'd0);
    guard = 0;
    while (!timeout && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("to_set", 32'(timeout), 32'd1);
    pop_one("to");
    check("to_clr", 32'(timeout), 32'd0);
    cfg_div = 16'd3;
`endif

    // Final drain.
    while (model_q.size() != 0) pop_one("final");
    check_status("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, RX byte FIFO entries, power of two.
REQ-002 SHALL have parameter IRQ_LVL, default 4, FIFO level at which irq asserts.
REQ-003 SHALL have parameter TIMEOUT_TICKS, default 640, sample ticks of idle before timeout (40 bit-times at 16x).
REQ-004 SHALL have ports, in this order:
- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous, active-low.
- cfg_en  in  1  receiver enable.
- cfg_div  in  16  sample-tick period minus 1, in clk cycles.
- cfg_no_parity  in  1  no parity bit.
- cfg_ev_parity  in  1  even parity; odd when 0.
- rx_data_sample  out  1  16x sample tick to receiver.
- rx_en  out  1  receiver enable.
- no_parity  out  1  latched parity mode.
- ev_parity  out  1  latched parity mode.
- rd_data_flag  out  1  receiver data-read strobe.
- rx_ok  in  1  receiver in stop phase; frame complete.
- rxd_out  in  8  received byte, valid while rd_data_flag is high.
- parity_error  in  1  parity check failed, valid while rx_ok is high.
- rd_en  in  1  host pop.
- rd_data  out  8  FIFO head.
- rd_valid  out  1  FIFO not empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entry count.
- overrun  out  1  sticky byte-dropped flag.
- perr  out  1  sticky parity-error flag.
- err_clr  in  1  clears overrun, perr and timeout.
- timeout  out  1  idle-timeout flag.
- irq  out  1  interrupt.

Function
REQ-005 Tick divider SHALL count down from cfg_div and pulse rx_data_sample for 1 cycle at 0, then reload; cfg_div=0 SHALL give a tick every cycle.
REQ-006 Divider SHALL be held at reload with no ticks while FSM is IDLE.
REQ-007 FSM states SHALL be IDLE, RUN, CAPT, DRAIN; encodings SHALL be defined in uart_define.v.
REQ-008 IDLE->RUN SHALL occur when cfg_en=1, and no_parity/ev_parity SHALL latch cfg_* on that edge; they SHALL stay stable outside IDLE.
REQ-009 RUN->CAPT SHALL occur when rx_ok=1; CAPT lasts exactly 1 cycle.
REQ-010 In CAPT, rd_data_flag SHALL be 1, rxd_out SHALL be pushed to the FIFO, and parity_error=1 SHALL set perr.
REQ-011 CAPT->DRAIN SHALL be unconditional; DRAIN->RUN SHALL occur when rx_ok=0, so there is 1 push per frame.
REQ-012 cfg_en=0 in any state SHALL force IDLE on the next edge, with rx_en=0 and no pending push.
REQ-013 FIFO contents and sticky flags SHALL be retained across cfg_en=0.
REQ-014 rx_en SHALL be 1 in RUN, CAPT and DRAIN.
REQ-015 A push when full SHALL drop the byte and set overrun.
REQ-016 Push and pop in the same cycle when full SHALL both occur, without overrun.
REQ-017 Pop when empty SHALL be ignored.
REQ-018 rd_data SHALL show the head combinationally and SHALL be 0 when empty.
REQ-019 Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-020 err_clr SHALL clear the sticky flags; a same-cycle set SHALL win over clear.
REQ-021 irq SHALL equal (fifo_level>=IRQ_LVL) | overrun | perr | timeout, as a registered output with 1-cycle latency.

Reset
REQ-022 rst_n=0 SHALL drive FSM to IDLE, empty the FIFO, and hold every output at 0 (rd_data 8'h00, fifo_level 0), with the divider at reload.

Configuration
REQ-023 With UART_RX_TIMEOUT_EN defined, an idle counter SHALL count ticks while rd_valid=1 and the FSM is in RUN.
REQ-024 With UART_RX_TIMEOUT_EN defined, the idle counter SHALL reset on CAPT, rd_en or empty, and SHALL set timeout when it reaches TIMEOUT_TICKS.
REQ-025 With UART_RX_TIMEOUT_EN defined, timeout SHALL clear on rd_en, CAPT or err_clr.
REQ-026 Without UART_RX_TIMEOUT_EN, timeout SHALL be constant 0 and no counter logic SHALL exist.

Structure
REQ-027 FSM state codes and the default FIFO depth SHALL live in uart_define.v.
REQ-028 The FIFO SHALL be sub-module uart_rx_fifo (synchronous, 1 clock, full/empty/level); the divider and FSM SHALL stay in uart_rx_ctrl.

Verification
REQ-029 cfg_div=3, cfg_en=1: rx_data_sample SHALL pulse every 4 clk cycles; with cfg_en=0, no pulses.
REQ-030 Model rx_ok high 8 ticks, rxd_out=8'hA5: exactly 1 push, rd_data=8'hA5, fifo_level=1, rd_data_flag high 1 cycle.
REQ-031 9 frames, no pops, FIFO_DEPTH=8: fifo_level=8, overrun=1, first 8 bytes intact.
REQ-032 Frame with parity_error=1: perr=1, irq=1, byte stored; err_clr clears perr.
REQ-033 cfg_en dropped mid-DRAIN: rx_en=0 next cycle, FSM IDLE, FIFO unchanged.
REQ-034 UART_RX_TIMEOUT_EN, TIMEOUT_TICKS=640, 1 byte unread: timeout=1 after 640 ticks; rd_en clears it.
